gpio_serial_loader: RTL and testbench

//  Hardware sequencer for the two GPIO configuration shift chains (user1: GPIO 18..0, user2: GPIO 19..37).
//  On request it reads each pad's 13-bit config word, shifts all words MSB-first into both chains in parallel,

---
 rtl/gpio_serial_pkg.sv | 19 +
 rtl/gpio_serial_tick.sv | 32 +++
 rtl/gpio_serial_loader.sv | 195 +++++++++++++++++++
 tb/tb_gpio_serial_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_serial_pkg.sv
// Shared types and defaults for the GPIO configuration chain loader.
// The optional bit-bang override is enabled with the GPIO_BITBANG_EN macro in gpio_serial_loader.
package gpio_serial_pkg;

  localparam int NUM_GPIO_DEFAULT = 19;
  localparam int CFG_BITS_DEFAULT = 13;
  localparam int CLK_DIV_DEFAULT  = 4;
  localparam int IDX_W            = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gpio_serial_tick.sv
// Phase timer for the serial chain clock: a down-counter that flags the last cycle of each
// CLK_DIV-long phase and restarts whenever the sequencer changes state or is idle.
module gpio_serial_tick
  import gpio_serial_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic en,
  input  logic clr,
  output logic phase_end
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign phase_end = en && (cnt_q == '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= CNT_LOAD;
    end else if (clr || !en || phase_end) begin
      cnt_q <= CNT_LOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts every pad's config word MSB-first into both GPIO chains, then strobes serial_load.
// Define GPIO_BITBANG_EN to add bb_* inputs that drive the chain pins directly while idle.
//
// state    | meaning
// IDLE     | waiting for start or pending rerun
// FETCH    | capture config words k into shift regs
// SHIFT_LO | serial clock low, present data bit
// SHIFT_HI | serial clock high, data held; shift on exit
// LOAD     | serial clock low, load strobe high
// DONE     | load released, one-cycle done pulse
module gpio_serial_loader
  import gpio_serial_pkg::*;
#(
  parameter int NUM_GPIO_PER_CHAIN = NUM_GPIO_DEFAULT,
  parameter int CFG_BITS           = CFG_BITS_DEFAULT,
  parameter int CLK_DIV            = CLK_DIV_DEFAULT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                xfer_start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [IDX_W-1:0]    cfg_idx1_o,
  output logic [IDX_W-1:0]    cfg_idx2_o,
  input  logic [CFG_BITS-1:0] cfg_data1_i,
  input  logic [CFG_BITS-1:0] cfg_data2_i,
  output logic                serial_clock_o,
  output logic                serial_load_o,
  output logic                serial_resetn_o,
  output logic                serial_data1_o,
  output logic                serial_data2_o
`ifdef GPIO_BITBANG_EN
  ,
  input  logic                bb_enable_i,
  input  logic                bb_resetn_i,
  input  logic                bb_load_i,
  input  logic                bb_clock_i,
  input  logic                bb_data1_i,
  input  logic                bb_data2_i
`endif
);

  localparam int BIT_W  = $clog2(CFG_BITS);
  localparam int WORD_W = $clog2(NUM_GPIO_PER_CHAIN);
  localparam logic [BIT_W-1:0]  FIRST_BIT = BIT_W'(CFG_BITS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_GPIO_PER_CHAIN - 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CFG_BITS-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
  logic                pend_q, pend_d;
  logic                resetn_q;
  logic                phase_end;
  logic                bb_hold;
  logic                start_ok, run_req;
  logic                fsm_clock, fsm_load, fsm_data1, fsm_data2, shifting;

  assign start_ok = xfer_start_i && !bb_hold;
  assign run_req  = start_ok || (pend_q && !bb_hold);

  gpio_serial_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .en        (state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI || state_q == ST_LOAD),
    .clr       (state_d != state_q),
    .phase_end (phase_end)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      bit_q    <= '0;
      sr1_q    <= '0;
      sr2_q    <= '0;
      pend_q   <= 1'b0;
      resetn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      bit_q    <= bit_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      pend_q   <= pend_d;
      resetn_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (run_req) begin
          state_d = ST_FETCH;
          word_d  = '0;
        end
      end
      ST_FETCH: begin
        sr1_d   = cfg_data1_i;
        sr2_d   = cfg_data2_i;
        bit_d   = FIRST_BIT;
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (phase_end) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          sr1_d = {sr1_q[CFG_BITS-2:0], 1'b0};
          sr2_d = {sr2_q[CFG_BITS-2:0], 1'b0};
          if (bit_q != '0) begin
            bit_d   = bit_q - 1'b1;
            state_d = ST_SHIFT_LO;
          end else if (word_q != LAST_WORD) begin
            word_d  = word_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (phase_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        word_d  = '0;
        state_d = run_req ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A start landing in DONE launches the rerun directly, so it is consumed here too.
    if ((state_q == ST_IDLE || state_q == ST_DONE) && state_d == ST_FETCH) begin
      pend_d = 1'b0;
    end else if (start_ok && state_q != ST_IDLE) begin
      pend_d = 1'b1;
    end
  end

  assign shifting   = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
  assign fsm_clock  = (state_q == ST_SHIFT_HI);
  assign fsm_load   = (state_q == ST_LOAD);
  assign fsm_data1  = shifting && sr1_q[CFG_BITS-1];
  assign fsm_data2  = shifting && sr2_q[CFG_BITS-1];

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign cfg_idx1_o = IDX_W'(NUM_GPIO_PER_CHAIN - 1) - IDX_W'(word_q);
  assign cfg_idx2_o = IDX_W'(NUM_GPIO_PER_CHAIN) + IDX_W'(word_q);

`ifdef GPIO_BITBANG_EN
  logic bb_en_q, bb_resetn_q, bb_load_q, bb_clock_q, bb_data1_q, bb_data2_q;
  logic bb_active;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bb_en_q     <= 1'b0;
      bb_resetn_q <= 1'b0;
      bb_load_q   <= 1'b0;
      bb_clock_q  <= 1'b0;
      bb_data1_q  <= 1'b0;
      bb_data2_q  <= 1'b0;
    end else begin
      bb_en_q     <= bb_enable_i;
      bb_resetn_q <= bb_resetn_i;
      bb_load_q   <= bb_load_i;
      bb_clock_q  <= bb_clock_i;
      bb_data1_q  <= bb_data1_i;
      bb_data2_q  <= bb_data2_i;
    end
  end

  // Bit-bang only takes the pins once the sequencer has returned to idle.
  assign bb_active       = bb_en_q && (state_q == ST_IDLE);
  assign bb_hold         = bb_enable_i;
  assign serial_clock_o  = bb_active ? bb_clock_q  : fsm_clock;
  assign serial_load_o   = bb_active ? bb_load_q   : fsm_load;
  assign serial_resetn_o = bb_active ? bb_resetn_q : resetn_q;
  assign serial_data1_o  = bb_active ? bb_data1_q  : fsm_data1;
  assign serial_data2_o  = bb_active ? bb_data2_q  : fsm_data2;
`else
  assign bb_hold         = 1'b0;
  assign serial_clock_o  = fsm_clock;
  assign serial_load_o   = fsm_load;
  assign serial_resetn_o = resetn_q;
  assign serial_data1_o  = fsm_data1;
  assign serial_data2_o  = fsm_data2;
`endif

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: a full-size instance (19,13,4) and a small one (2,13,1).
// Build with GPIO_BITBANG_EN defined to also exercise the bit-bang override.
module tb_gpio_serial_loader;

  localparam int N_B = 19, C_B = 13, D_B = 4;
  localparam int N_S = 2, D_S = 1;
  localparam int T_BIG   = N_B * (1 + 2 * C_B * D_B) + D_B + 1;
  localparam int T_SMALL = N_S * (1 + 2 * C_B * D_S) + D_S + 1;
  localparam int NROWS   = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start_big = 1'b0, start_small = 1'b0;

  logic b_busy, b_done, b_sclk, b_load, b_rstn, b_d1, b_d2;
  logic [5:0] b_idx1, b_idx2;
  logic [12:0] b_cfg1, b_cfg2;
  logic s_busy, s_done, s_sclk, s_load, s_rstn, s_d1, s_d2;
  logic [5:0] s_idx1, s_idx2;
  logic [12:0] s_cfg1, s_cfg2;

  assign b_cfg1 = 13'h1809;
  assign b_cfg2 = 13'h0403;
  assign s_cfg1 = (s_idx1 == 6'd1) ? 13'h1000 : 13'h0001;
  assign s_cfg2 = (s_idx2 == 6'd2) ? 13'h0002 : 13'h1FFE;

`ifdef GPIO_BITBANG_EN
  logic bb_en = 1'b0, bb_rstn = 1'b0, bb_ld = 1'b0, bb_clk = 1'b0, bb_d1 = 1'b0, bb_d2 = 1'b0;
`endif

  gpio_serial_loader u_big (
    .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start_i(start_big),
    .busy_o(b_busy), .done_o(b_done), .cfg_idx1_o(b_idx1), .cfg_idx2_o(b_idx2),
    .cfg_data1_i(b_cfg1), .cfg_data2_i(b_cfg2),
    .serial_clock_o(b_sclk), .serial_load_o(b_load), .serial_resetn_o(b_rstn),
    .serial_data1_o(b_d1), .serial_data2_o(b_d2)
`ifdef GPIO_BITBANG_EN
    , .bb_enable_i(bb_en), .bb_resetn_i(bb_rstn), .bb_load_i(bb_ld),
    .bb_clock_i(bb_clk), .bb_data1_i(bb_d1), .bb_data2_i(bb_d2)
`endif
  );

  gpio_serial_loader #(.NUM_GPIO_PER_CHAIN(N_S), .CFG_BITS(C_B), .CLK_DIV(D_S)) u_small (
    .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start_i(start_small),
    .busy_o(s_busy), .done_o(s_done), .cfg_idx1_o(s_idx1), .cfg_idx2_o(s_idx2),
    .cfg_data1_i(s_cfg1), .cfg_data2_i(s_cfg2),
    .serial_clock_o(s_sclk), .serial_load_o(s_load), .serial_resetn_o(s_rstn),
    .serial_data1_o(s_d1), .serial_data2_o(s_d2)
`ifdef GPIO_BITBANG_EN
    , .bb_enable_i(1'b0), .bb_resetn_i(1'b0), .bb_load_i(1'b0),
    .bb_clock_i(1'b0), .bb_data1_i(1'b0), .bb_data2_i(1'b0)
`endif
  );

  int n_checks = 0, n_fail = 0;

  // Chain models: each rising serial clock pushes the current data bit in.
  logic [246:0] chain1, chain2;
  logic [25:0]  schain1, schain2;
  int b_bits = 0;
  always @(posedge b_sclk) begin
    chain1 = {chain1[245:0], b_d1};
    chain2 = {chain2[245:0], b_d2};
    b_bits++;
  end
  always @(posedge s_sclk) begin
    schain1 = {schain1[24:0], s_d1};
    schain2 = {schain2[24:0], s_d2};
  end

  int b_busy_cnt = 0, b_done_cnt = 0, b_load_hi = 0, b_load_rise = 0, b_busy_rise = 0;
  int s_load_rise = 0, edge_viol = 0;
  logic [246:0] snap1, snap2;
  logic [25:0]  ssnap1, ssnap2;
  logic pb_busy = 1'b0, pb_load = 1'b0, pb_sclk = 1'b0, pb_d1 = 1'b0, pb_d2 = 1'b0;
  logic ps_load = 1'b0, ps_sclk = 1'b0, ps_d1 = 1'b0, ps_d2 = 1'b0;

  always @(negedge clk) begin
    if (b_busy) b_busy_cnt++;
    if (b_busy && !pb_busy) b_busy_rise++;
    if (b_done) b_done_cnt++;
    if (b_load) b_load_hi++;
    if (b_load && !pb_load) begin
      b_load_rise++;
      snap1 = chain1;
      snap2 = chain2;
    end
    if (s_load && !ps_load) begin
      s_load_rise++;
      ssnap1 = schain1;
      ssnap2 = schain2;
    end
    if (b_sclk && !pb_sclk && (b_d1 != pb_d1 || b_d2 != pb_d2 || b_load != pb_load)) edge_viol++;
    if (s_sclk && !ps_sclk && (s_d1 != ps_d1 || s_d2 != ps_d2 || s_load != ps_load)) edge_viol++;
    pb_busy = b_busy; pb_load = b_load; pb_sclk = b_sclk; pb_d1 = b_d1; pb_d2 = b_d2;
    ps_load = s_load; ps_sclk = s_sclk; ps_d1 = s_d1; ps_d2 = s_d2;
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_chain(input string name, input logic [246:0] act, input logic [246:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_big();
    @(negedge clk); start_big = 1'b1;
    @(negedge clk); start_big = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (b_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (b_busy) begin
      n_fail++;
      n_checks++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    int         cyc;
    logic       busy, sclk, load, done, d1, d2;
    logic [5:0] idx1, idx2;
  } vec_t;

  function automatic vec_t mk(int c, logic bu, logic sc, logic ld, logic dn, logic x1, logic x2,
                              logic [5:0] i1, logic [5:0] i2);
    vec_t v;
    v.cyc = c; v.busy = bu; v.sclk = sc; v.load = ld; v.done = dn;
    v.d1 = x1; v.d2 = x2; v.idx1 = i1; v.idx2 = i2;
    return v;
  endfunction

  vec_t tbl [NROWS];

  initial begin
    int b0, d0, l0, lr0, br0, bits0, n, r;
    logic [246:0] exp1, exp2;

    exp1 = {19{13'h1809}};
    exp2 = {19{13'h0403}};

    // Small instance timeline: words GPIO1=0x1000/GPIO0=0x0001, GPIO2=0x0002/GPIO3=0x1FFE.
    tbl[0]  = mk(0,  1, 0, 0, 0, 0, 0, 6'd1, 6'd2);
    tbl[1]  = mk(1,  1, 0, 0, 0, 1, 0, 6'd1, 6'd2);
    tbl[2]  = mk(2,  1, 1, 0, 0, 1, 0, 6'd1, 6'd2);
    tbl[3]  = mk(3,  1, 0, 0, 0, 0, 0, 6'd1, 6'd2);
    tbl[4]  = mk(23, 1, 0, 0, 0, 0, 1, 6'd1, 6'd2);
    tbl[5]  = mk(26, 1, 1, 0, 0, 0, 0, 6'd1, 6'd2);
    tbl[6]  = mk(27, 1, 0, 0, 0, 0, 0, 6'd0, 6'd3);
    tbl[7]  = mk(28, 1, 0, 0, 0, 0, 1, 6'd0, 6'd3);
    tbl[8]  = mk(53, 1, 1, 0, 0, 1, 0, 6'd0, 6'd3);
    tbl[9]  = mk(54, 1, 0, 1, 0, 0, 0, 6'd0, 6'd3);
    tbl[10] = mk(55, 1, 0, 0, 1, 0, 0, 6'd0, 6'd3);
    tbl[11] = mk(56, 0, 0, 0, 0, 0, 0, 6'd1, 6'd2);
    tbl[12] = mk(57, 0, 0, 0, 0, 0, 0, 6'd1, 6'd2);

    // Reset asserted mid-cycle: outputs must take reset values at once.
    #2 rst = 1'b1;
    #1;
    check_int("reset_big", int'({b_busy, b_done, b_sclk, b_load, b_rstn, b_d1, b_d2, b_idx1, b_idx2}),
              int'({7'b0, 6'd18, 6'd19}));
    check_int("reset_small", int'({s_busy, s_done, s_sclk, s_load, s_rstn, s_d1, s_d2, s_idx1, s_idx2}),
              int'({7'b0, 6'd1, 6'd2}));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_int("resetn_release", int'({b_rstn, s_rstn, b_busy, s_busy}), int'(4'b1100));

    // Full-size transfer.
    b0 = b_busy_cnt; d0 = b_done_cnt; l0 = b_load_hi; lr0 = b_load_rise;
    pulse_big();
    wait_idle("full_idle", T_BIG + 50);
    check_int("full_busy_cycles", b_busy_cnt - b0, T_BIG);
    check_int("full_done_pulses", b_done_cnt - d0, 1);
    check_int("full_load_cycles", b_load_hi - l0, D_B);
    check_int("full_load_rises", b_load_rise - lr0, 1);
    check_chain("full_chain1", snap1, exp1);
    check_chain("full_chain2", snap2, exp2);

    // Three starts while busy collapse into a single back-to-back rerun.
    b0 = b_busy_cnt; d0 = b_done_cnt; lr0 = b_load_rise; br0 = b_busy_rise;
    pulse_big();
    repeat (100) @(negedge clk);
    pulse_big();
    repeat (50) @(negedge clk);
    pulse_big();
    repeat (50) @(negedge clk);
    pulse_big();
    wait_idle("rerun_idle", 2 * T_BIG + 50);
    check_int("rerun_done_pulses", b_done_cnt - d0, 2);
    check_int("rerun_busy_cycles", b_busy_cnt - b0, 2 * T_BIG);
    check_int("rerun_busy_rises", b_busy_rise - br0, 1);
    check_int("rerun_load_rises", b_load_rise - lr0, 2);

    // Reset around bit 100 aborts with no load and no done.
    d0 = b_done_cnt; lr0 = b_load_rise; bits0 = b_bits;
    pulse_big();
    n = 0;
    while (b_bits - bits0 < 100 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_int("abort_reached_bit100", int'(b_bits - bits0 >= 100), 1);
    #2 rst = 1'b1;
    #1;
    check_int("abort_outputs", int'({b_busy, b_done, b_sclk, b_load, b_rstn, b_d1, b_d2}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_int("abort_no_done", b_done_cnt - d0, 0);
    check_int("abort_no_load", b_load_rise - lr0, 0);

    b0 = b_busy_cnt; d0 = b_done_cnt;
    pulse_big();
    wait_idle("clean_idle", T_BIG + 50);
    check_int("clean_busy_cycles", b_busy_cnt - b0, T_BIG);
    check_int("clean_done_pulses", b_done_cnt - d0, 1);
    check_chain("clean_chain1", snap1, exp1);
    check_chain("clean_chain2", snap2, exp2);

    // Small instance: cycle-exact vectors after the start edge.
    lr0 = s_load_rise;
    @(negedge clk); start_small = 1'b1;
    r = 0;
    for (int cyc = 0; cyc <= 57; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) start_small = 1'b0;
      if (r < NROWS && tbl[r].cyc == cyc) begin
        check_int($sformatf("small_vec_c%0d", cyc),
                  int'({s_busy, s_sclk, s_load, s_done, s_d1, s_d2, s_idx1, s_idx2}),
                  int'({tbl[r].busy, tbl[r].sclk, tbl[r].load, tbl[r].done,
                        tbl[r].d1, tbl[r].d2, tbl[r].idx1, tbl[r].idx2}));
        r++;
      end
    end
    @(negedge clk);
    check_int("small_load_rises", s_load_rise - lr0, 1);
    check_int("small_chain1", int'(ssnap1), int'({13'h1000, 13'h0001}));
    check_int("small_chain2", int'(ssnap2), int'({13'h0002, 13'h1FFE}));
    check_int("small_busy_total", T_SMALL, 56);

    check_int("clock_edge_stability", edge_viol, 0);

`ifdef GPIO_BITBANG_EN
    @(negedge clk); bb_en = 1'b1; bb_rstn = 1'b1;
    repeat (2) @(negedge clk);
    bb_clk = 1'b1; bb_d1 = 1'b1;
    #1;
    check_int("bb_before_edge", int'({b_sclk, b_d1}), 0);
    @(negedge clk);
    check_int("bb_after_edge", int'({b_sclk, b_d1, b_rstn}), int'(3'b111));
    bb_clk = 1'b0;
    @(negedge clk);
    check_int("bb_clock_low", int'(b_sclk), 0);
    b0 = b_busy_cnt;
    pulse_big();
    repeat (10) @(negedge clk);
    check_int("bb_start_ignored", b_busy_cnt - b0, 0);
    bb_en = 1'b0;
    repeat (10) @(negedge clk);
    check_int("bb_start_not_pended", b_busy_cnt - b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
